serial_subtractor: RTL and testbench

Bit-serial, parametrised-width subtractor that computes D = A − B − Bin one bit per clock, LSB first. It reuses a single full-subtractor cell and a registered borrow, trading latency for area. It sits in the arithmetic datapath wherever wide subtraction is needed without a WIDTH-bit ripple chain. A start/busy/done handshake launches and completes each operation, and the block reports both unsigned borrow-out and signed overflow.

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/fs_bit_cell.sv | 18 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for bit-serial arithmetic blocks: FSM state encoding
// and the single-bit full-subtractor equations.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Difference bit of a - b - bin
  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  // Borrow out of a - b - bin
  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_bit_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational cell built from the shared package equations
  always_comb begin
    d    = fs_diff(a, b, bin);
    bout = fs_borrow(a, b, bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a registered borrow replace a
// WIDTH-bit ripple chain; start/busy/done handshake around each operation.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bout;

  // The one shared arithmetic cell works on the current LSBs and borrow
  fs_bit_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic: accept, shift one bit per RUN cycle, latch results at the end
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        r_d  = {cell_d, r_q[WIDTH-1:1]};
        br_d = cell_bout;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish result, final borrow and signed overflow
          state_d = DONE;
          d_d     = {cell_d, r_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output combinationally
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    D    = d_q;
    Bout = bout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8) with a result scoreboard.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             ovf;

  int      n_checks = 0;
  int      n_errors = 0;
  result_t sb[$];
  result_t last_exp;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, independent of the bit-serial structure
  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic bin);
    result_t r;
    int ua, ub, sa, sb_i, sdiff;
    ua    = int'(a);
    ub    = int'(b);
    sa    = int'($signed(a));
    sb_i  = int'($signed(b));
    sdiff = sa - sb_i - int'(bin);
    r.d    = WIDTH'(ua - ub - int'(bin));
    r.bout = (ua < ub + int'(bin));
    r.ovf  = (sdiff > 127) || (sdiff < -128);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request (caller is at a negedge); returns just after the accepting edge
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the accept edge until done; check busy, latency and result
  task automatic wait_done(input int lat0, input int exp_lat);
    int      lat;
    bit      seen;
    result_t exp;
    lat  = lat0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else check("busy_run", 32'(busy), 32'd1);
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_at_done", 32'(busy), 32'd0);
      if (sb.size() > 0) begin
        exp      = sb.pop_front();
        last_exp = exp;
        check("D", 32'(D), 32'(exp.d));
        check("Bout", 32'(Bout), 32'(exp.bout));
        check("ovf", 32'(ovf), 32'(exp.ovf));
      end else begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end
    end
  endtask

  initial begin
    int done_cnt;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Basic and boundary operations, each from IDLE
    @(negedge clk); launch(8'h5A, 8'h23, 1'b0); wait_done(0, 9);
    @(negedge clk); launch(8'h00, 8'h01, 1'b0); wait_done(0, 9);
    @(negedge clk); launch(8'h80, 8'h01, 1'b0); wait_done(0, 9);
    @(negedge clk); launch(8'h7F, 8'hFF, 1'b0); wait_done(0, 9);
    @(negedge clk); launch(8'h10, 8'h0F, 1'b1); wait_done(0, 9);
    @(negedge clk); launch(8'h00, 8'h00, 1'b1); wait_done(0, 9);

    // Result holds after done while idle
    repeat (3) @(negedge clk);
    check("D_hold", 32'(D), 32'(last_exp.d));
    check("Bout_hold", 32'(Bout), 32'(last_exp.bout));
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back: second request issued in the DONE cycle
    @(negedge clk); launch(8'hC3, 8'h3C, 1'b0); wait_done(0, 9);
    launch(8'h01, 8'h02, 1'b1); wait_done(0, 9);

    // start held high with changing operands during RUN
    @(negedge clk);
    A     = 8'h3C;
    B     = 8'h5A;
    Bin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(8'h3C, 8'h5A, 1'b0));
    @(posedge clk);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      A   = WIDTH'($urandom);
      B   = WIDTH'($urandom);
      Bin = 1'($urandom);
      check("held_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    check("held_busy8", 32'(busy), 32'd1);
    wait_done(8, 9);

    // Asynchronous reset in the middle of RUN
    @(negedge clk); launch(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_D", 32'(D), 32'd0);
    check("arst_Bout", 32'(Bout), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", 32'(done_cnt), 32'd0);
    launch(8'hFF, 8'h01, 1'b0); wait_done(0, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
